// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch counter slice.
// The optional lap capture is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX        = 4'd9;
    localparam int   DEF_NUM_DIGITS = 4;
    localparam int   DEF_TICK_DIV   = 1000;

    typedef enum logic [2:0] {
        IDLE,
        RUN_ONE,
        RUN_TEN,
        PAUSE,
        CLEAR
    } mode_t;

    // Mode inputs are nominally one-hot; overlap resolves clear > pause > ten > one.
    function automatic mode_t resolve_mode(
        input logic one,
        input logic ten,
        input logic pause,
        input logic clr
    );
        mode_t m;
        m = IDLE;
        if (clr)        m = CLEAR;
        else if (pause) m = PAUSE;
        else if (ten)   m = RUN_TEN;
        else if (one)   m = RUN_ONE;
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Mode-in / count-out bundle between the mode FSM, counter and display.
// Lap signals exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_if
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
);
    logic                    one_run_push;
    logic                    ten_run_push;
    logic                    pause_push;
    logic                    clear_push;
    logic [4*NUM_DIGITS-1:0] count_bcd;
    logic                    running;
    logic                    rollover;
`ifdef STOPWATCH_LAP_EN
    logic                    lap_strobe;
    logic [4*NUM_DIGITS-1:0] lap_bcd;

    modport master (
        output one_run_push, ten_run_push, pause_push, clear_push,
        output lap_strobe,
        input  count_bcd, running, rollover, lap_bcd
    );
    modport slave (
        input  one_run_push, ten_run_push, pause_push, clear_push,
        input  lap_strobe,
        output count_bcd, running, rollover, lap_bcd
    );
`else
    modport master (
        output one_run_push, ten_run_push, pause_push, clear_push,
        input  count_bcd, running, rollover
    );
    modport slave (
        input  one_run_push, ten_run_push, pause_push, clear_push,
        output count_bcd, running, rollover
    );
`endif
endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// Single decade counter; carry_out is combinational so a chain ripples in one cycle.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry_out
);
    bcd_t r_digit;
    logic w_at_max;

    assign w_at_max  = (r_digit == BCD_MAX);
    assign carry_out = inc & w_at_max;
    assign digit     = r_digit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_digit <= '0;
        else if (clr)
            r_digit <= '0;
        else if (inc)
            r_digit <= w_at_max ? '0 : r_digit + 4'd1;
    end
endmodule

// File: rtl/stopwatch_counter.sv
// Prescaled packed-BCD stopwatch count with +1/+10 run modes.
// Define STOPWATCH_LAP_EN to add the lap capture register.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
)(
    input  logic        clk,
    input  logic        n_rst,
    stopwatch_if.slave  bus
);
    localparam int             PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

    mode_t                   w_mode;
    logic                    w_run;
    logic                    w_clr;
    logic                    w_tick;
    logic [NUM_DIGITS-1:0]   w_inc;
    logic [NUM_DIGITS-1:0]   w_carry;
    logic [4*NUM_DIGITS-1:0] w_count;

    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_rollover;

    assign w_mode = resolve_mode(bus.one_run_push, bus.ten_run_push,
                                 bus.pause_push, bus.clear_push);
    assign w_run  = (w_mode == RUN_ONE) | (w_mode == RUN_TEN);
    assign w_clr  = (w_mode == CLEAR);
    assign w_tick = w_run & (r_presc == PMAX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_presc <= '0;
        else if (w_clr)
            r_presc <= '0;
        else if (w_run)
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end

    // Ten-run injects the tick at digit 1 so the units digit is untouched.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        if (g == 0) begin : g_lsd
            assign w_inc[g] = w_tick & (w_mode == RUN_ONE);
        end else if (g == 1) begin : g_tens
            assign w_inc[g] = w_carry[0] | (w_tick & (w_mode == RUN_TEN));
        end else begin : g_upper
            assign w_inc[g] = w_carry[g-1];
        end

        bcd_digit u_digit (
            .clk       (clk),
            .n_rst     (n_rst),
            .clr       (w_clr),
            .inc       (w_inc[g]),
            .digit     (w_count[4*g +: 4]),
            .carry_out (w_carry[g])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_running  <= 1'b0;
            r_rollover <= 1'b0;
        end else begin
            r_running  <= w_run;
            r_rollover <= w_carry[NUM_DIGITS-1];
        end
    end

    assign bus.count_bcd = w_count;
    assign bus.running   = r_running;
    assign bus.rollover  = r_rollover;

`ifdef STOPWATCH_LAP_EN
    logic [4*NUM_DIGITS-1:0] r_lap;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_lap <= '0;
        else if (w_clr)
            r_lap <= '0;
        else if (bus.lap_strobe)
            r_lap <= w_count;
    end

    assign bus.lap_bcd = r_lap;
`endif
endmodule
